mem_lsu: RTL

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/rv64_mem_pkg.sv | 58 +++++
 rtl/load_align.sv | 29 ++
 rtl/mem_lsu.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rv64_mem_pkg.sv
// Shared encodings and helpers for the RV64 load/store unit.
package rv64_mem_pkg;

   localparam int DATA_WIDTH = 64;

   localparam logic [2:0] F3_LB      = 3'b000;
   localparam logic [2:0] F3_LH      = 3'b001;
   localparam logic [2:0] F3_LW      = 3'b010;
   localparam logic [2:0] F3_LD      = 3'b011;
   localparam logic [2:0] F3_LBU     = 3'b100;
   localparam logic [2:0] F3_LHU     = 3'b101;
   localparam logic [2:0] F3_LWU     = 3'b110;
   localparam logic [2:0] F3_ILLEGAL = 3'b111;

   localparam logic [7:0] STRB_BYTE   = 8'h01;
   localparam logic [7:0] STRB_HALF   = 8'h03;
   localparam logic [7:0] STRB_WORD   = 8'h0F;
   localparam logic [7:0] STRB_DOUBLE = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_t;

   // Natural alignment: the byte offset must be a multiple of the access size.
   function automatic logic f_aligned(input logic [1:0] size, input logic [2:0] off);
      case (size)
         2'd0:    return 1'b1;
         2'd1:    return ~off[0];
         2'd2:    return (off[1:0] == 2'b00);
         default: return (off == 3'b000);
      endcase
   endfunction

   function automatic logic [7:0] f_strb(input logic [1:0] size, input logic [2:0] off);
      logic [7:0] mask;
      case (size)
         2'd0:    mask = STRB_BYTE;
         2'd1:    mask = STRB_HALF;
         2'd2:    mask = STRB_WORD;
         default: mask = STRB_DOUBLE;
      endcase
      return mask << off;
   endfunction

   // Low bytes of the store data copied into every lane so the strobes pick the right one.
   function automatic logic [63:0] f_wdata(input logic [1:0] size, input logic [63:0] data);
      case (size)
         2'd0:    return {8{data[7:0]}};
         2'd1:    return {4{data[15:0]}};
         2'd2:    return {2{data[31:0]}};
         default: return data;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed lane out of a doubleword read and sign/zero extends it.
module load_align
   import rv64_mem_pkg::*;
(
   input  logic [63:0] i_rdata,
   input  logic [2:0]  i_offset,
   input  logic [2:0]  i_funct3,
   output logic [63:0] o_result
);

   logic [63:0] w_shifted;

   // Shift the addressed byte down to lane 0, then extend by access type.
   always_comb begin
      w_shifted = i_rdata >> {i_offset, 3'b000};
      o_result  = '0;
      case (i_funct3)
         F3_LB:   o_result = {{56{w_shifted[7]}},  w_shifted[7:0]};
         F3_LH:   o_result = {{48{w_shifted[15]}}, w_shifted[15:0]};
         F3_LW:   o_result = {{32{w_shifted[31]}}, w_shifted[31:0]};
         F3_LD:   o_result = w_shifted;
         F3_LBU:  o_result = {56'd0, w_shifted[7:0]};
         F3_LHU:  o_result = {48'd0, w_shifted[15:0]};
         F3_LWU:  o_result = {32'd0, w_shifted[31:0]};
         default: o_result = '0;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: one outstanding access, stalls the pipeline until the bus completes.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | accept an aligned access (stall same cycle) or pulse o_fault
// REQ     | o_bus_req high with latched address/data until granted
// WAIT    | load granted, waiting for i_bus_rvalid
// DONE    | one cycle: stall released, o_load_valid for loads
module mem_lsu
   import rv64_mem_pkg::*;
#(
   parameter int DATA_WIDTH = rv64_mem_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_mem_rd,
   input  logic                  i_mem_wr,
   input  logic [2:0]            i_funct3,
   input  logic [DATA_WIDTH-1:0] i_aluout,
   input  logic [DATA_WIDTH-1:0] i_wr_mem_data,
   input  logic [4:0]            i_Rd,
   output logic                  o_stall,
   output logic                  o_load_valid,
   output logic [DATA_WIDTH-1:0] o_load_data,
   output logic [4:0]            o_Rd,
   output logic                  o_fault,
   output logic                  o_bus_req,
   input  logic                  i_bus_gnt,
   output logic                  o_bus_we,
   output logic [DATA_WIDTH-1:0] o_bus_addr,
   output logic [DATA_WIDTH-1:0] o_bus_wdata,
   output logic [7:0]            o_bus_wstrb,
   input  logic                  i_bus_rvalid,
   input  logic [DATA_WIDTH-1:0] i_bus_rdata
);

   lsu_state_t            r_state;
   lsu_state_t            w_state_nxt;
   logic [DATA_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_load_data;
   logic [7:0]            r_wstrb;
   logic [2:0]            r_funct3;
   logic [4:0]            r_rd;
   logic                  r_we;
   logic                  w_access;
   logic                  w_legal;
   logic [DATA_WIDTH-1:0] w_load_result;

   assign w_access = i_mem_rd | i_mem_wr;
   // funct3 111 has no load meaning; stores only look at the size bits.
   assign w_legal  = (i_mem_rd ^ i_mem_wr)
                   && f_aligned(i_funct3[1:0], i_aluout[2:0])
                   && !(i_mem_rd && (i_funct3 == F3_ILLEGAL));

   load_align u_load_align (
      .i_rdata  (i_bus_rdata),
      .i_offset (r_addr[2:0]),
      .i_funct3 (r_funct3),
      .o_result (w_load_result)
   );

   // State register plus the access fields captured on acceptance and the load result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_funct3    <= '0;
         r_rd        <= '0;
         r_we        <= 1'b0;
         r_load_data <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == ST_IDLE) && w_legal) begin
            r_addr   <= i_aluout;
            r_wdata  <= f_wdata(i_funct3[1:0], i_wr_mem_data);
            r_wstrb  <= f_strb(i_funct3[1:0], i_aluout[2:0]);
            r_funct3 <= i_funct3;
            r_rd     <= i_Rd;
            r_we     <= i_mem_wr;
         end
         if ((r_state == ST_WAIT) && i_bus_rvalid) begin
            r_load_data <= w_load_result;
         end
      end
   end

   // Next state and all handshake outputs; bus outputs are zero outside REQ.
   always_comb begin
      w_state_nxt  = r_state;
      o_stall      = 1'b0;
      o_fault      = 1'b0;
      o_load_valid = 1'b0;
      o_bus_req    = 1'b0;
      o_bus_we     = 1'b0;
      o_bus_addr   = '0;
      o_bus_wdata  = '0;
      o_bus_wstrb  = '0;
      case (r_state)
         ST_IDLE: begin
            if (!rst) begin
               if (w_legal) begin
                  o_stall     = 1'b1;
                  w_state_nxt = ST_REQ;
               end else if (w_access) begin
                  o_fault = 1'b1;
               end
            end
         end
         ST_REQ: begin
            o_stall     = 1'b1;
            o_bus_req   = 1'b1;
            o_bus_we    = r_we;
            o_bus_addr  = {r_addr[DATA_WIDTH-1:3], 3'b000};
            o_bus_wdata = r_wdata;
            o_bus_wstrb = r_wstrb;
            if (i_bus_gnt) begin
               w_state_nxt = r_we ? ST_DONE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            o_stall = 1'b1;
            if (i_bus_rvalid) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            o_load_valid = !r_we;
            w_state_nxt  = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign o_load_data = r_load_data;
   assign o_Rd        = r_rd;

endmodule
